// File: rtl/pll_lock_sequencer_if.sv
// PLL lock/reset handshake bundle between the lock sequencer (master) and the PLL/reset consumers (slave).
interface pll_lock_sequencer_if #(
    parameter int NDOMAINS = 4
);
    logic                pll_locked;
    logic                force_relock;
    logic                pll_rst;
    logic [NDOMAINS-1:0] domain_rst;
    logic                all_ready;
    logic [7:0]          relock_cnt;

    modport master (
        input  pll_locked,
        input  force_relock,
        output pll_rst,
        output domain_rst,
        output all_ready,
        output relock_cnt
    );

    modport slave (
        output pll_locked,
        output force_relock,
        input  pll_rst,
        input  domain_rst,
        input  all_ready,
        input  relock_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Pulses PLL reset until lock is stable, then releases per-domain resets one by one.
// Every output is registered and derived from the next FSM state.
module pll_lock_sequencer #(
    parameter int NDOMAINS            = 4,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pll_lock_sequencer_if.master   bus
);
    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_B   = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ? LOCK_STABLE_CYCLES : STAGGER_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (NDOMAINS > 1) ? $clog2(NDOMAINS) : 1;

    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NDOMAINS - 1);

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    count, count_nx;
    logic [IDX_W-1:0]    idx, idx_nx;
    logic [7:0]          relock_q, relock_nx;
    logic [NDOMAINS-1:0] domain_q, domain_nx;
    logic                pll_rst_q, pll_rst_nx;
    logic                all_ready_q, all_ready_nx;
    logic                sync_p0, sync_p1;
    logic                lk;

    // synchronizer stage boundary: pll_locked -> sync_p0 -> sync_p1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= bus.pll_locked;
            sync_p1 <= sync_p0;
        end
    end

    assign lk = sync_p1;

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        idx_nx    = idx;
        relock_nx = relock_q;
        case (state)
            S_PLLRST: begin
                if (count == PLL_LAST) begin
                    state_nx = S_WAIT_LOCK;
                    count_nx = '0;
                end else begin
                    count_nx = count + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_nx = S_STABLE;
                    count_nx = '0;
                end else if (count == TIMEOUT_LAST) begin
                    state_nx = S_PLLRST;
                    count_nx = '0;
                end else begin
                    count_nx = count + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_nx = S_WAIT_LOCK;
                    count_nx = '0;
                end else if (count == STABLE_LAST) begin
                    state_nx = S_RELEASE;
                    count_nx = '0;
                    idx_nx   = '0;
                end else begin
                    count_nx = count + 1'b1;
                end
            end
            S_RELEASE, S_RUN: begin
                if (!lk) begin
                    state_nx  = S_WAIT_LOCK;
                    count_nx  = '0;
                    relock_nx = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                end else if (state == S_RELEASE) begin
                    if (count == STAGGER_LAST) begin
                        count_nx = '0;
                        if (idx == IDX_LAST) state_nx = S_RUN;
                        else                 idx_nx   = idx + 1'b1;
                    end else begin
                        count_nx = count + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_PLLRST;
                count_nx = '0;
            end
        endcase

        // A forced relock overrides any lock-loss bookkeeping from the same cycle
        if (bus.force_relock && state != S_PLLRST) begin
            state_nx  = S_PLLRST;
            count_nx  = '0;
            relock_nx = relock_q;
        end

        pll_rst_nx   = (state_nx == S_PLLRST);
        all_ready_nx = (state_nx == S_RUN);
        for (int i = 0; i < NDOMAINS; i++) begin
            domain_nx[i] = 1'b1;
            if (state_nx == S_RUN)
                domain_nx[i] = 1'b0;
            else if (state_nx == S_RELEASE && int'(idx_nx) >= i)
                domain_nx[i] = 1'b0;
        end
    end

    // state/output register boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_PLLRST;
            count       <= '0;
            idx         <= '0;
            relock_q    <= '0;
            domain_q    <= '1;
            pll_rst_q   <= 1'b1;
            all_ready_q <= 1'b0;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            idx         <= idx_nx;
            relock_q    <= relock_nx;
            domain_q    <= domain_nx;
            pll_rst_q   <= pll_rst_nx;
            all_ready_q <= all_ready_nx;
        end
    end

    assign bus.pll_rst    = pll_rst_q;
    assign bus.domain_rst = domain_q;
    assign bus.all_ready  = all_ready_q;
    assign bus.relock_cnt = relock_q;
endmodule
